// File: rtl/lifo_arbiter_pkg.sv
// Shared constants and helpers for the LIFO arbiter slice.
// No logic; imported by the arbiter top and its round-robin sub-module.
// Holds the default requester count and the wrap-around pointer helper.
package lifo_arbiter_pkg;

    localparam int LIFO_ARBITER_DEFAULT_REQUESTERS = 4;

    // Index that follows 'index' in a ring of 'count' slots.
    function automatic int ring_next(input int index, input int count);
        return (index + 1 >= count) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/lifo_arbiter_round_robin_arbiter.sv
// Round-robin one-hot selector with a rotating priority pointer.
// Latency: grant is combinational; the pointer moves on the accepting edge.
// Backpressure: grant is forced low during reset; the pointer holds when nothing is accepted.
module round_robin_arbiter
    import lifo_arbiter_pkg::*;
#(
    parameter int REQUESTERS      = LIFO_ARBITER_DEFAULT_REQUESTERS,
    parameter int REQUESTERS_LOG2 = $clog2(REQUESTERS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [REQUESTERS-1:0]      eligible,
    input  logic                       grant_accept,
    output logic [REQUESTERS-1:0]      grant,
    output logic [REQUESTERS_LOG2-1:0] grant_index
);

    logic [REQUESTERS_LOG2-1:0] priority_pointer;

    // Search upward from the pointer, wrapping, and take the first eligible requester.
    always_comb begin
        int  idx;
        logic found;
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(priority_pointer) + k) % REQUESTERS;
            if (!found && eligible[idx] && !reset) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_index = REQUESTERS_LOG2'(idx);
            end
        end
    end

    // Rotate priority to just past the requester that was served.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            priority_pointer <= '0;
        end else if (grant_accept) begin
            priority_pointer <= REQUESTERS_LOG2'(ring_next(int'(grant_index), REQUESTERS));
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO stack controller between REQUESTERS push/pop clients, round-robin.
// Latency: grant and controller enables are combinational; pop response is registered, 1 cycle after grant.
// Backpressure: pushes wait while full, pops wait while empty (unless LIFO_ARBITER_EMPTY_ERROR_EN is defined).
module lifo_arbiter
    import lifo_arbiter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int REQUESTERS      = LIFO_ARBITER_DEFAULT_REQUESTERS,
    parameter int REQUESTERS_LOG2 = $clog2(REQUESTERS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [REQUESTERS-1:0]       request_valid,
    input  logic [REQUESTERS-1:0]       request_push,
    input  logic [REQUESTERS*WIDTH-1:0] request_data,
    output logic [REQUESTERS-1:0]       request_ready,
    output logic [REQUESTERS-1:0]       response_valid,
    output logic [WIDTH-1:0]            response_data,
    output logic                        response_error,
    input  logic                        lifo_full,
    input  logic                        lifo_empty,
    output logic                        lifo_write_enable,
    output logic [WIDTH-1:0]            lifo_write_data,
    output logic                        lifo_read_enable,
    input  logic [WIDTH-1:0]            lifo_read_data
);

    logic [REQUESTERS-1:0]      eligible;
    logic [REQUESTERS-1:0]      grant;
    logic [REQUESTERS_LOG2-1:0] grant_index;
    logic                       any_grant;
    logic                       grant_is_push;
    logic                       pop_allowed;
    logic                       pop_on_empty;
    logic [WIDTH-1:0]           request_word [REQUESTERS];

`ifdef LIFO_ARBITER_EMPTY_ERROR_EN
    // Pops on an empty stack are served with an error response instead of waiting.
    assign pop_allowed  = 1'b1;
    assign pop_on_empty = lifo_empty;
`else
    assign pop_allowed  = !lifo_empty;
    assign pop_on_empty = 1'b0;
`endif

    // Split the flat push-data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            request_word[i] = request_data[i*WIDTH +: WIDTH];
        end
    end

    // A request competes only if the stack can take it this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            eligible[i] = request_valid[i] && (request_push[i] ? !lifo_full : pop_allowed);
        end
    end

    round_robin_arbiter #(
        .REQUESTERS      (REQUESTERS),
        .REQUESTERS_LOG2 (REQUESTERS_LOG2)
    ) u_round_robin_arbiter (
        .clock        (clock),
        .reset        (reset),
        .eligible     (eligible),
        .grant_accept (any_grant),
        .grant        (grant),
        .grant_index  (grant_index)
    );

    // The arbiter already suppresses grants in reset, so ready is the grant itself.
    assign any_grant     = |grant;
    assign grant_is_push = request_push[grant_index];
    assign request_ready = grant;

    // Drive the controller; read and write enables are mutually exclusive by construction.
    always_comb begin
        lifo_write_enable = any_grant && grant_is_push;
        lifo_read_enable  = any_grant && !grant_is_push && !pop_on_empty;
        lifo_write_data   = request_word[grant_index];
    end

    // Return the popped word to the winner one cycle after its grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            response_valid <= '0;
            response_data  <= '0;
        end else begin
            response_valid <= (any_grant && !grant_is_push) ? grant : '0;
            if (any_grant && !grant_is_push) begin
                response_data <= pop_on_empty ? '0 : lifo_read_data;
            end
        end
    end

`ifdef LIFO_ARBITER_EMPTY_ERROR_EN
    // Flag the response that answers a pop made against an empty stack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            response_error <= 1'b0;
        end else begin
            response_error <= any_grant && !grant_is_push && pop_on_empty;
        end
    end
`else
    assign response_error = 1'b0;
`endif

endmodule
